// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle DIV/DIVU unit: FSM states, handshake levels,
// ALU op codes and the operand magnitude helper.
package div_pkg;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  localparam logic DIV_RESULT_READY     = 1'b1;
  localparam logic DIV_RESULT_NOT_READY = 1'b0;
  localparam logic DIV_START            = 1'b1;
  localparam logic DIV_STOP             = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  // Magnitude of a signed operand; unsigned operands pass through untouched.
  function automatic logic [31:0] abs_operand(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU: 32 shift/subtract iterations, a sign-fix
// pass, then {remainder, quotient} held while EX keeps start_i asserted.
module div
  import div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state;
  logic [5:0]  cnt;
  logic [64:0] dividend;
  logic [31:0] divisor;
  logic        neg_quot;
  logic        neg_rem;
  logic [32:0] trial;

  // Partial remainder sits in dividend[64:33]; the next dividend bit is folded in at [32].
  always_comb begin
    trial = {1'b0, dividend[63:32]} - {1'b0, divisor};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_FREE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      neg_quot <= 1'b0;
      neg_rem  <= 1'b0;
      result_o <= '0;
      ready_o  <= DIV_RESULT_NOT_READY;
    end else begin
      case (state)
        DIV_FREE: begin
          if (start_i && !annul_i) begin
            if (opdata2_i == '0) begin
              state <= DIV_BY_ZERO;
            end else begin
              state    <= DIV_ON;
              cnt      <= '0;
              dividend <= {32'b0, abs_operand(opdata1_i, signed_div_i), 1'b0};
              divisor  <= abs_operand(opdata2_i, signed_div_i);
            end
            neg_quot <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem  <= signed_div_i & opdata1_i[31];
          end
          result_o <= '0;
          ready_o  <= DIV_RESULT_NOT_READY;
        end

        DIV_BY_ZERO: begin
          dividend <= '0;
          state    <= DIV_END;
        end

        DIV_ON: begin
          if (start_i && !annul_i) begin
            if (cnt != 6'd32) begin
              if (trial[32]) begin
                dividend <= {dividend[63:0], 1'b0};
              end else begin
                dividend <= {trial[31:0], dividend[31:0], 1'b1};
              end
              cnt <= cnt + 6'd1;
            end else begin
              if (neg_quot) dividend[31:0]  <= ~dividend[31:0] + 32'd1;
              if (neg_rem)  dividend[64:33] <= ~dividend[64:33] + 32'd1;
              state <= DIV_END;
              cnt   <= '0;
            end
          end else begin
            state    <= DIV_FREE;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end

        DIV_END: begin
          if (start_i) begin
            result_o <= {dividend[64:33], dividend[31:0]};
            ready_o  <= DIV_RESULT_READY;
          end else begin
            state    <= DIV_FREE;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
          end
        end

        default: state <= DIV_FREE;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: an arithmetic/latency model compared every cycle,
// plus directed vectors with literal results and latencies.
module tb_div;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div dut (
    .clk         (clk),
    .rst         (rst),
    .signed_div_i(signed_div_i),
    .opdata1_i   (opdata1_i),
    .opdata2_i   (opdata2_i),
    .start_i     (start_i),
    .annul_i     (annul_i),
    .result_o    (result_o),
    .ready_o     (ready_o)
  );

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Plain arithmetic reference: truncating division, remainder takes the dividend's sign.
  function automatic logic [63:0] model_result(input logic s, input logic [31:0] a,
                                               input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    sa = s ? longint'($signed(a)) : longint'({32'b0, a});
    sb = s ? longint'($signed(b)) : longint'({32'b0, b});
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Cycle model: counts edges since acceptance instead of tracking FSM states.
  bit          model_on = 0;
  bit          m_busy = 0;
  bit          m_zero = 0;
  int          m_elapsed = 0;
  int          m_k = 0;
  logic [63:0] m_exp = '0;
  logic        exp_ready = 1'b0;
  logic [63:0] exp_result = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0;
      exp_ready = 1'b0;
      exp_result = '0;
      model_on = 1;
    end else if (!m_busy) begin
      if (start_i && !annul_i) begin
        m_busy = 1;
        m_elapsed = 0;
        m_zero = (opdata2_i == '0);
        m_k = m_zero ? 2 : 34;
        m_exp = model_result(signed_div_i, opdata1_i, opdata2_i);
      end
    end else begin
      m_elapsed++;
      if (m_elapsed < m_k) begin
        if (!m_zero && (!start_i || annul_i)) m_busy = 0;
      end else if (start_i) begin
        exp_ready = 1'b1;
        exp_result = m_exp;
      end else begin
        m_busy = 0;
        exp_ready = 1'b0;
        exp_result = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check64("model_ready", {63'b0, ready_o}, {63'b0, exp_ready});
      check64("model_result", result_o, exp_result);
    end
  end

  task automatic wait_ready(input string name, input logic [63:0] exp, input int lat,
                            input bit scramble);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (scramble && cyc == 2) begin
        opdata1_i = ~opdata1_i;
        opdata2_i = opdata2_i + 32'd5;
        signed_div_i = ~signed_div_i;
      end
    end while (!ready_o && cyc < 100);
    check64({name, "_latency"}, 64'(cyc - 1), 64'(lat));
    check64({name, "_result"}, result_o, exp);
  endtask

  task automatic drop_start(input string name, input logic [63:0] exp);
    @(negedge clk);
    check64({name, "_held_ready"}, {63'b0, ready_o}, 64'd1);
    check64({name, "_held_result"}, result_o, exp);
    start_i = 1'b0;
    @(negedge clk);
    check64({name, "_drop_ready"}, {63'b0, ready_o}, 64'd0);
    check64({name, "_drop_result"}, result_o, 64'd0);
  endtask

  task automatic run_op(input string name, input logic s, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    signed_div_i = s;
    opdata1_i = a;
    opdata2_i = b;
    annul_i = 1'b0;
    start_i = 1'b1;
    wait_ready(name, exp, lat, 1'b1);
    drop_start(name, exp);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check64("reset_ready", {63'b0, ready_o}, 64'd0);
    check64("reset_result", result_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("divu_7_2",     1'b0, 32'd7,        32'd2,        64'h00000001_00000003, 34);
    run_op("div_m7_2",     1'b1, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD, 34);
    run_op("div_7_m2",     1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34);
    run_op("divu_5_0",     1'b0, 32'd5,        32'd0,        64'h0, 2);
    run_op("div_5_0",      1'b1, 32'd5,        32'd0,        64'h0, 2);
    run_op("divu_max_1",   1'b0, 32'hFFFFFFFF, 32'd1,        64'h00000000_FFFFFFFF, 34);
    run_op("div_ovf",      1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
    run_op("divu_big",     1'b0, 32'hDEADBEEF, 32'h00012345, model_result(1'b0, 32'hDEADBEEF, 32'h00012345), 34);
    run_op("div_neg_neg",  1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 34);

    // Annul partway through, then a fresh request on the following cycle.
    signed_div_i = 1'b0;
    opdata1_i = 32'd1000;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    check64("annul_ready", {63'b0, ready_o}, 64'd0);
    annul_i = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    wait_ready("annul_restart", 64'h00000002_0000000E, 34, 1'b0);
    drop_start("annul_restart", 64'h00000002_0000000E);

    // Reset mid-iteration with start held: a new division begins after release.
    opdata1_i = 32'hFFFFFFFF;
    opdata2_i = 32'd3;
    start_i = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check64("rst_mid_ready", {63'b0, ready_o}, 64'd0);
    check64("rst_mid_result", result_o, 64'd0);
    rst = 1'b0;
    opdata1_i = 32'd100;
    opdata2_i = 32'd7;
    wait_ready("rst_restart", 64'h00000002_0000000E, 34, 1'b0);

    // Reset while the result is being held.
    rst = 1'b1;
    @(negedge clk);
    check64("rst_end_ready", {63'b0, ready_o}, 64'd0);
    check64("rst_end_result", result_o, 64'd0);
    rst = 1'b0;
    start_i = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
